// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding and
// default geometry of the instruction memory it fetches from.
package ifu_pkg;

  localparam int IFU_ADDR_W   = 16;
  localparam int IFU_DATA_W   = 16;
  localparam int IFU_DEPTH    = 16;
  localparam int IFU_RESET_PC = 0;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/pc_wrap_inc.sv
// Next sequential fetch address, wrapping from DEPTH-1 back to 0 so the
// result always stays inside the instruction memory.
module pc_wrap_inc #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic [ADDR_W-1:0] x,
  output logic [ADDR_W-1:0] y
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  assign y = (x == LAST) ? '0 : x + ADDR_W'(1);

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF-stage fetch initiator: owns the PC, hides the one-cycle memory read
// latency, and handles stall, redirect and out-of-range redirect faults.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int ADDR_W   = IFU_ADDR_W,
  parameter int DATA_W   = IFU_DATA_W,
  parameter int DEPTH    = IFU_DEPTH,
  parameter int RESET_PC = IFU_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic [DATA_W-1:0] Instruction,
  output logic [ADDR_W-1:0] ReadAddress,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid_out,
  output logic              fault,
  output logic [15:0]       fetch_count
);

  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

  ifu_state_t        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              req_valid;
  logic [ADDR_W-1:0] pc_inc;
  logic              running;
  logic              target_ok;
  logic              replay;

  pc_wrap_inc #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_pc_inc (
    .x(pc),
    .y(pc_inc)
  );

  assign running   = (state == ST_RUN);
  assign target_ok = ({1'b0, redirect_target} < DEPTH_V);
  assign valid_out = running && req_valid && !redirect_valid;

  // Re-issuing req_pc while stalled keeps Instruction stable on the next cycle.
  assign replay      = running && stall && req_valid && !redirect_valid;
  assign ReadAddress = replay ? req_pc : pc;

  assign instr_out = Instruction;
  assign pc_out    = req_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_HALT;
      pc          <= PC_RST;
      req_pc      <= PC_RST;
      req_valid   <= 1'b0;
      fault       <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      case (state)
        ST_HALT: begin
          // The memory already holds RESET_PC on its address port, so the
          // first word is treated as in flight from the start cycle.
          if (start) begin
            state     <= ST_RUN;
            req_pc    <= pc;
            req_valid <= 1'b1;
            pc        <= pc_inc;
          end
        end
        ST_RUN: begin
          if (redirect_valid) begin
            req_valid <= 1'b0;
            if (target_ok) begin
              pc <= redirect_target;
            end else begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end
          end else if (!(stall && req_valid)) begin
            req_pc    <= pc;
            req_valid <= 1'b1;
            pc        <= pc_inc;
            if (valid_out) begin
              fetch_count <= fetch_count + 16'd1;
            end
          end
        end
        default: begin
          // FAULT is terminal until reset; everything stays frozen.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: free run with wrap, stall,
// redirect, fault and mid-run reset against a registered-read memory model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic [15:0] Instruction;
  logic [15:0] ReadAddress;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        valid_out;
  logic        fault;
  logic [15:0] fetch_count;

  int n_chk;
  int n_fail;
  int fc;
  int p;

  instruction_fetch_unit #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .DEPTH   (16),
    .RESET_PC(0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .Instruction    (Instruction),
    .ReadAddress    (ReadAddress),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word[i] = 16'h1000 + i, one-cycle registered read.
  always @(posedge clk) Instruction <= 16'h1000 + ReadAddress;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 16'h0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_addr", ReadAddress, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_fault", fault, 0);
    chk("rst_count", fetch_count, 0);

    @(negedge clk); rst = 1'b1; #1;
    chk("halt_valid", valid_out, 0);
    @(negedge clk); #1;
    chk("halt_valid2", valid_out, 0);
    chk("halt_addr", ReadAddress, 0);

    // Start pulse, then free run across the DEPTH-1 -> 0 wrap.
    @(negedge clk); start = 1'b1; #1;
    chk("start_valid", valid_out, 0);
    fc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); start = 1'b0; #1;
      p = i % 16;
      chk("run_valid", valid_out, 1);
      chk("run_pc", pc_out, p);
      chk("run_instr", instr_out, 16'h1000 + p);
      chk("run_addr", ReadAddress, (p + 1) % 16);
      chk("run_count", fetch_count, fc);
      fc++;
    end
    @(negedge clk); #1;
    chk("pre_stall_pc", pc_out, 4);
    fc++;

    // Stall three cycles on pc_out=5.
    @(negedge clk); stall = 1'b1; #1;
    chk("stall_pc", pc_out, 5);
    chk("stall_valid", valid_out, 1);
    chk("stall_addr", ReadAddress, 5);
    chk("stall_count", fetch_count, fc);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("stall_pc_h", pc_out, 5);
      chk("stall_instr_h", instr_out, 16'h1005);
      chk("stall_valid_h", valid_out, 1);
      chk("stall_addr_h", ReadAddress, 5);
      chk("stall_count_h", fetch_count, fc);
    end
    @(negedge clk); stall = 1'b0; #1;
    chk("unstall_pc", pc_out, 5);
    chk("unstall_addr", ReadAddress, 6);
    chk("unstall_count", fetch_count, fc);
    fc++;
    @(negedge clk); #1;
    chk("post_stall_pc", pc_out, 6);
    chk("post_stall_instr", instr_out, 16'h1006);
    chk("post_stall_count", fetch_count, fc);
    fc++;

    p = 6;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      p = (p + 1) % 16;
      chk("run2_pc", pc_out, p);
      chk("run2_count", fetch_count, fc);
      fc++;
    end

    // Redirect to 9 while pc_out=3, with stall also asserted.
    @(negedge clk); stall = 1'b1; redirect_valid = 1'b1; redirect_target = 16'd9; #1;
    chk("redir_valid", valid_out, 0);
    chk("redir_pc", pc_out, 3);
    chk("redir_addr", ReadAddress, 4);
    @(negedge clk); stall = 1'b0; redirect_valid = 1'b0; #1;
    chk("bubble_valid", valid_out, 0);
    chk("bubble_addr", ReadAddress, 9);
    chk("bubble_count", fetch_count, fc);
    @(negedge clk); #1;
    chk("tgt_valid", valid_out, 1);
    chk("tgt_pc", pc_out, 9);
    chk("tgt_instr", instr_out, 16'h1009);
    chk("tgt_count", fetch_count, fc);
    fc++;
    @(negedge clk); #1;
    chk("tgt_next_pc", pc_out, 10);
    fc++;

    // Out-of-range redirect while pc_out=11 (pc=12) -> sticky fault.
    @(negedge clk); redirect_valid = 1'b1; redirect_target = 16'h0020; #1;
    chk("bad_redir_valid", valid_out, 0);
    chk("bad_redir_fault", fault, 0);
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk("fault_set", fault, 1);
    chk("fault_valid", valid_out, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); start = (k == 3); #1;
      chk("fault_valid_h", valid_out, 0);
      chk("fault_h", fault, 1);
      chk("fault_addr", ReadAddress, 12);
      chk("fault_count", fetch_count, fc);
    end
    start = 1'b0;

    @(negedge clk); rst = 1'b0; #1;
    chk("frst_fault", fault, 0);
    chk("frst_valid", valid_out, 0);
    chk("frst_addr", ReadAddress, 0);
    chk("frst_count", fetch_count, 0);
    chk("frst_pc", pc_out, 0);

    // Restart and abort with an asynchronous reset while pc_out=7.
    @(negedge clk); rst = 1'b1; start = 1'b1; #1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); start = 1'b0; #1;
      chk("run3_pc", pc_out, i);
      chk("run3_count", fetch_count, i);
    end
    #2 rst = 1'b0; #1;
    chk("arst_valid", valid_out, 0);
    chk("arst_addr", ReadAddress, 0);
    chk("arst_pc", pc_out, 0);
    chk("arst_count", fetch_count, 0);
    @(negedge clk); rst = 1'b1; start = 1'b1; #1;
    chk("restart_valid", valid_out, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); start = 1'b0; #1;
      chk("restart_v", valid_out, 1);
      chk("restart_pc", pc_out, i);
      chk("restart_instr", instr_out, 16'h1000 + i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch-side initiator for the synchronous instruction memory. It owns the PC, drives ReadAddress, and absorbs the memory's one-cycle registered read latency. It presents each fetched word to the decode stage with its PC and a valid flag, and handles downstream stall, branch/jump redirect, and out-of-range faults. It sits at the IF stage of the 5-stage pipeline, between the hazard/branch logic and the IF/ID register.

Parameters:
ADDR_W, 16, width of PC, ReadAddress and redirect_target
DATA_W, 16, instruction word width
DEPTH, 16, instruction memory depth in words; legal addresses are 0..DEPTH-1
RESET_PC, 0, PC loaded on reset; must be < DEPTH

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; HALT -> RUN
stall  in  1  decode cannot accept; hold the current fetch
redirect_valid  in  1  branch/jump taken this cycle
redirect_target  in  ADDR_W  new fetch address
Instruction  in  DATA_W  memory read data, registered one cycle after ReadAddress
ReadAddress  out  ADDR_W  memory read address (combinational from registers and stall)
instr_out  out  DATA_W  instruction to decode (pass-through of Instruction)
pc_out  out  ADDR_W  address of instr_out (req_pc)
valid_out  out  1  instr_out/pc_out are a real, non-squashed instruction
fault  out  1  sticky; redirect_target >= DEPTH was seen
fetch_count  out  16  instructions accepted by decode (valid_out && !stall), wraps at 2^16

Behaviour:
- Registers: state {HALT, RUN, FAULT}, pc (next address to issue), req_pc (address whose data is on Instruction now), req_valid, fault, fetch_count.
- Reset (async, rst low): state=HALT, pc=RESET_PC, req_pc=RESET_PC, req_valid=0, fault=0, fetch_count=0. Outputs therefore read ReadAddress=RESET_PC, valid_out=0, pc_out=RESET_PC. instr_out follows Instruction, which is don't-care while valid_out=0.
- valid_out = (state==RUN) && req_valid && !redirect_valid.
- ReadAddress = req_pc when (state==RUN && stall && req_valid && !redirect_valid), else pc. Replaying req_pc during a stall keeps Instruction stable next cycle.
- inc(x) = (x==DEPTH-1) ? 0 : x+1. The PC wraps modulo DEPTH and never leaves 0..DEPTH-1.
- HALT: holds all registers. start=1 -> RUN. Other inputs are ignored.
- RUN, priority highest first:
  1. redirect_valid with target < DEPTH: pc<=target, req_valid<=0. Target instruction gets valid_out=1 two cycles later (2-bubble penalty). The redirect wins over stall.
  2. redirect_valid with target >= DEPTH: state<=FAULT, fault<=1, req_valid<=0.
  3. stall && req_valid: pc, req_pc, req_valid and fetch_count all hold.
  4. Otherwise: req_pc<=pc, req_valid<=1, pc<=inc(pc). fetch_count increments when valid_out.
  - A stall while req_valid=0 does not block advance, since a bubble needs no holding.
- Throughput: one instruction per cycle with no stall or redirect. First valid_out comes 1 cycle after the start cycle, at pc_out=RESET_PC.
- FAULT: valid_out=0, registers frozen, ReadAddress=pc. Exit only via rst.
- rst asserted mid-stream aborts immediately. The in-flight fetch is dropped with no valid_out.
- start in RUN or FAULT is ignored.

Decomposition:
- Shared package ifu_pkg: state encoding (HALT=2'd0, RUN=2'd1, FAULT=2'd2), ADDR_W/DATA_W defaults, DEPTH, RESET_PC.
- One sub-module, pc_wrap_inc: combinational inc() with DEPTH wrap. It is reused by the branch-target logic.
- Everything else lives in the top module.

Test Plan:
- Reset, then start at cycle 0, memory word[i]=16'h1000+i, no stall -> valid_out=1 from cycle 1 with pc_out=0,1,2,...; instr_out=16'h1000+pc_out; fetch_count=N after N accepts.
- Free run past DEPTH-1=15 -> pc_out sequence 14,15,0,1 with no gap in valid_out; ReadAddress never exceeds 15.
- Stall held 3 cycles while pc_out=5 -> pc_out=5, instr_out=16'h1005 and valid_out=1 held; ReadAddress=5 during stall; fetch_count unchanged; pc_out=6 on the first cycle after stall drops.
- Redirect to 9 while pc_out=3 and stall=1 -> valid_out=0 that cycle and the next; then pc_out=9, instr_out=16'h1009, valid_out=1.
- Redirect to 16'h0020 -> fault=1 next cycle; valid_out stays 0 for 10+ cycles; start ignored; rst low clears fault and returns to HALT.
- rst pulsed low mid-run at pc_out=7 -> valid_out=0 and ReadAddress=RESET_PC immediately; after start, stream restarts at 0.
